// File: rtl/matrix_decoder.sv
// matrix_decoder: iterative decoder for a 5x5 bit-matrix cipher.
// A word and its round key are accepted in IDLE. RUN then applies one inverse round per
// clock, for r = ROUNDS-1 down to 0. Each inverse round is: XOR with the key, transpose,
// then rotate row y right by (y+r) mod 5. DONE presents the result until it is taken.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous, active-high reset
//   in_valid  : encoded word and key present
//   in_ready  : block can accept a word (IDLE only)
//   in_data   : encoded matrix, bit index 5*y + x
//   key       : round key, captured with in_data
//   out_valid : decoded word present (DONE only)
//   out_ready : consumer accepts the decoded word
//   out_data  : decoded matrix, zero while out_valid is low
//   busy      : high in RUN and DONE
module matrix_decoder #(
  parameter int unsigned ROUNDS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_data,
  input  logic [24:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [24:0] data_q, data_d;
  logic [24:0] key_q, key_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [24:0] round_out;

  // One inverse round, purely combinational.
  function automatic logic [24:0] dec_round(input logic [24:0] m, input logic [24:0] k,
                                            input logic [4:0] r);
    logic [24:0] a;
    logic [24:0] t;
    logic [24:0] o;
    int unsigned rm;
    int unsigned s;
    a  = m ^ k;
    t  = '0;
    o  = '0;
    rm = 32'(r) % 5;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        t[5*y+x] = a[5*x+y];
      end
    end
    // Right rotation: destination column x takes source column (x + s) mod 5.
    for (int unsigned y = 0; y < 5; y++) begin
      s = (y + rm) % 5;
      for (int unsigned x = 0; x < 5; x++) begin
        o[5*y+x] = t[5*y+((x+s)%5)];
      end
    end
    return o;
  endfunction

  assign round_out = dec_round(data_q, key_q, rnd_q);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          key_d   = key;
          rnd_d   = 5'(ROUNDS - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        data_d = round_out;
        if (rnd_q == 5'd0) begin
          state_d = StDone;
        end else begin
          rnd_d = rnd_q - 5'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_matrix_decoder.sv
module tb_matrix_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: ROUNDS = 1
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [24:0] a_in_data, a_key, a_out_data;
  // Instance b: ROUNDS = 24
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [24:0] b_in_data, b_key, b_out_data;

  matrix_decoder #(.ROUNDS(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .key       (a_key),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .busy      (a_busy)
  );

  matrix_decoder #(.ROUNDS(24)) u_dut24 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .key       (b_key),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .busy      (b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Forward cipher: rotate rows left, transpose, XOR key; rounds 0..rounds-1.
  function automatic logic [24:0] encode(input logic [24:0] m, input logic [24:0] k,
                                         input int rounds);
    logic [24:0] a;
    logic [24:0] b;
    logic [24:0] cur;
    cur = m;
    for (int r = 0; r < rounds; r++) begin
      a = '0;
      b = '0;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          a[5*y + (x+y+r)%5] = cur[5*y+x];
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          b[5*x+y] = a[5*y+x];
      cur = b ^ k;
    end
    return cur;
  endfunction

  typedef struct {
    logic [24:0] din;
    logic [24:0] k;
    logic [24:0] exp;
  } vec_t;

  // Single word through the ROUNDS=1 instance; called just after a negedge in IDLE.
  task automatic run1(input logic [24:0] d, input logic [24:0] k, input logic [24:0] e);
    a_in_data   = d;
    a_key       = k;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    check("r1_in_ready", 25'(a_in_ready), 25'd1);
    @(negedge clk);
    a_in_valid = 1'b0;
    check("r1_run_valid", 25'(a_out_valid), 25'd0);
    check("r1_run_data", a_out_data, 25'd0);
    @(negedge clk);
    check("r1_valid", 25'(a_out_valid), 25'd1);
    check("r1_data", a_out_data, e);
    @(negedge clk);
    check("r1_back_idle", 25'(a_in_ready), 25'd1);
  endtask

  // Single word through the ROUNDS=24 instance; called just after a negedge in IDLE.
  // junk keeps in_valid high with random data/key for the whole transaction.
  task automatic run24(input logic [24:0] m, input logic [24:0] k, input bit throttle,
                       input bit junk, input bit chk_busy);
    int cnt;
    int n;
    int busy_cnt;
    b_in_data  = encode(m, k, 24);
    b_key      = k;
    b_in_valid = 1'b1;
    check("r24_in_ready", 25'(b_in_ready), 25'd1);
    @(negedge clk);
    cnt      = 1;
    busy_cnt = 0;
    check("r24_not_ready_run", 25'(b_in_ready), 25'd0);
    while (!b_out_valid && cnt < 60) begin
      if (b_busy) busy_cnt++;
      if (junk) begin
        b_in_valid = 1'b1;
        b_in_data  = 25'($urandom);
        b_key      = 25'($urandom);
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    check("r24_latency", 25'(cnt), 25'd25);
    n = 0;
    while (b_out_valid && n < 300) begin
      if (b_busy) busy_cnt++;
      check("r24_data", b_out_data, m);
      check("r24_in_ready_done", 25'(b_in_ready), 25'd0);
      b_out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk) begin
        b_in_data = 25'($urandom);
        b_key     = 25'($urandom);
      end
      @(negedge clk);
      n++;
    end
    b_out_ready = 1'b0;
    check("r24_done_exit", 25'(b_out_valid), 25'd0);
    check("r24_idle_data", b_out_data, 25'd0);
    check("r24_idle_ready", 25'(b_in_ready), 25'd1);
    if (chk_busy) check("r24_busy_cycles", 25'(busy_cnt), 25'd25);
  endtask

  initial begin
    vec_t tbl[8];
    logic [24:0] m;
    logic [24:0] k;
    bit saw_valid;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_key = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_key = '0; b_out_ready = 1'b0;

    tbl[0] = '{din: 25'h0000002, k: 25'h0, exp: 25'h0000200};
    tbl[1] = '{din: 25'h1ABCDEF, k: 25'h1ABCDEF, exp: 25'h0};
    tbl[2] = '{din: 25'h1FFFFFF, k: 25'h0, exp: 25'h1FFFFFF};
    tbl[3] = '{din: 25'h0000001, k: 25'h0, exp: 25'h0000001};
    for (int i = 4; i < 8; i++) begin
      m = 25'($urandom);
      k = 25'($urandom);
      tbl[i] = '{din: encode(m, k, 1), k: k, exp: m};
    end

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 25'(b_in_ready), 25'd1);
    check("rst_out_valid", 25'(b_out_valid), 25'd0);
    check("rst_out_data", b_out_data, 25'd0);
    check("rst_busy", 25'(b_busy), 25'd0);
    check("rst_busy1", 25'(a_busy), 25'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors on ROUNDS=1
    for (int i = 0; i < 8; i++) run1(tbl[i].din, tbl[i].k, tbl[i].exp);

    // All ones through 24 rounds, out_ready tied high, busy for 25 cycles
    run24(25'h1FFFFFF, 25'h0, 1'b0, 1'b0, 1'b1);
    check("ones_encode", encode(25'h1FFFFFF, 25'h0, 24), 25'h1FFFFFF);

    // Reset priority over a handshake on the same edge
    b_in_data  = 25'h1234567;
    b_key      = 25'h0;
    b_in_valid = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    b_in_valid = 1'b0;
    check("rstprio_busy", 25'(b_busy), 25'd0);
    check("rstprio_ready", 25'(b_in_ready), 25'd1);
    @(negedge clk);
    check("rstprio_still_idle", 25'(b_busy), 25'd0);

    // Reset on the 10th RUN cycle abandons the word
    m = 25'($urandom);
    k = 25'($urandom);
    b_in_data  = encode(m, k, 24);
    b_key      = k;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", 25'(b_busy), 25'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 25'(b_in_ready), 25'd1);
    check("midrst_valid", 25'(b_out_valid), 25'd0);
    check("midrst_data", b_out_data, 25'd0);
    check("midrst_busy", 25'(b_busy), 25'd0);
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (b_out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 25'(saw_valid), 25'd0);
    run24(25'($urandom), 25'($urandom), 1'b0, 1'b0, 1'b1);

    // in_valid held high with changing data/key; next accept on first IDLE cycle
    run24(25'h0F0F0F0, 25'h1555555, 1'b1, 1'b1, 1'b0);
    run24(25'h1C3A5E7, 25'h0ABCDEF, 1'b0, 1'b1, 1'b0);
    b_in_valid = 1'b0;
    @(negedge clk);

    // Random pairs with throttled consumer
    for (int i = 0; i < 1000; i++) begin
      run24(25'($urandom), 25'($urandom), 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
